axi_burst_xfer_master: RTL and testbench
========================================

Name: axi_burst_xfer_master

Overview:
- Parameterised AXI4 burst master that takes one user transfer command of up to 2^XFER_LEN_W beats and splits it into legal AXI bursts.
- Each burst is at most MAX_BURST_LEN beats and never crosses a 4 KB boundary.
- Full valid/ready handshakes on every AXI channel; user write and read data are streamed with backpressure; per-transfer error status is aggregated.
- Sits between a DMA/traffic-generator controller and an AXI interconnect slave port.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width in bits (32/64/128/256); BYTES = DATA_W/8
MAX_BURST_LEN, 16, max beats per burst (power of two, 1..256)
XFER_LEN_W, 16, width of cmd_len

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE
cmd_w_r  in  1  0=write, 1=read
cmd_addr  in  ADDR_W  start byte address; low log2(BYTES) bits ignored (forced 0)
cmd_len  in  XFER_LEN_W  total beats minus 1
wr_data/wr_strb/wr_valid  in  DATA_W/BYTES/1  user write stream
wr_ready  out  1  write beat accepted
rd_data  out  DATA_W  = m_axi_rdata
rd_valid  out  1  = m_axi_rvalid in RDATA
rd_last  out  1  last beat of whole transfer
rd_ready  in  1  user read backpressure
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at transfer end
resp  out  2  aggregated response
m_axi_aw{addr,len,size,burst,valid}/awready; m_axi_w{data,strb,last,valid}/wready; m_axi_b{resp,valid}/bready; m_axi_ar{addr,len,size,burst,valid}/arready; m_axi_r{data,resp,last,valid}/rready  AXI4 master (len 8b, size 3b = log2(BYTES), burst 2'b01 INCR)

Behaviour:
- Reset: state IDLE; every valid/ready/last/done/busy output 0; resp 0; addr/len outputs 0; cmd_ready 1. Reset mid-transfer abandons the transfer; no further handshakes, no done.
- States: IDLE, CALC, ADDR, WDATA, BRESP, RDATA, DONE.
- IDLE: cmd_valid&cmd_ready latches addr, remaining=cmd_len+1, dir; resp cleared -> CALC.
- CALC (1 cycle): beats_4k = (4096 - addr[11:0]) >> log2(BYTES); blen = min(remaining, MAX_BURST_LEN, beats_4k); registered -> ADDR.
- ADDR: aw/arvalid=1, addr=cur addr, len=blen-1; held stable until ready. Handshake -> WDATA (write) or RDATA (read). Latency cmd accept -> first a*valid = 2 cycles.
- WDATA: wvalid=wr_valid, wr_ready=wready, wdata/wstrb pass-through; beat counted on wvalid&wready; wlast=1 when count==blen-1; last handshake -> BRESP. Write data only after AW accepted.
- BRESP: bready=1; on bvalid merge bresp; remaining-=blen; addr+=blen*BYTES; remaining==0 -> DONE else CALC.
- RDATA: rready=rd_ready; rd_valid=rvalid; each rvalid&rready merges rresp; rd_last=rlast & (remaining==blen); rlast handshake -> DONE or CALC as in BRESP.
- Response merge: resp latches the first non-OKAY (non-00) response; later responses ignored; all OKAY -> 00.
- DONE: done=1 one cycle, resp valid, -> IDLE. resp held until next command accepted.
- Arithmetic: remaining is XFER_LEN_W+1 bits; address wraps modulo 2^ADDR_W; cmd_len max (all ones) legal.
- Read rlast early/late relative to count: state exit on rlast handshake only.

Test Plan:
- Write cmd_addr 0x1000, cmd_len 3, slave always ready -> one AW awaddr 0x1000 awlen 3, 4 W beats, wlast on 4th, done with resp 00.
- Write cmd_addr 0x0, cmd_len 39, MAX 16, DATA_W 64 -> awlen 15,15,7 at 0x0,0x80,0x100; wr_ready only in WDATA; one done.
- Read cmd_addr 0xFE0, cmd_len 7, DATA_W 64 -> arlen 3 @0xFE0, arlen 3 @0x1000; rd_last only on 8th beat.
- Backpressure: awready low 5 cycles -> awvalid/awaddr/awlen stable; random wready/wr_valid -> no beat lost or duplicated; rd_ready low -> rready low, no rd beat lost.
- Errors: 3-burst write, bresp 00,10,11 -> resp=10 at done; read with one rresp 11 mid-burst -> resp=11.
- aresetn low mid-WDATA -> all valids 0 immediately; after release cmd_ready=1, no done; new command completes normally.

Source files
------------

// File: rtl/axi_burst_xfer_master_if.sv
// AXI4 master-side bus bundle for the burst transfer engine.
// Address, write, response and read channels with full handshakes.
interface axi_burst_xfer_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awvalid;
    logic                m_axi_awready;

    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;

    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;

    logic [ADDR_W-1:0]   m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arvalid;
    logic                m_axi_arready;

    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rlast;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_burst_xfer_master.sv
// AXI4 burst master: splits one user transfer into INCR bursts
// bounded by MAX_BURST_LEN and 4 KB pages, streams data, merges errors.
module axi_burst_xfer_master #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int MAX_BURST_LEN = 16,
    parameter int XFER_LEN_W    = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_w_r,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [XFER_LEN_W-1:0] cmd_len,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            resp,
    axi_burst_xfer_master_if.master m_axi
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int RW    = XFER_LEN_W + 1;
    localparam int CW    = (RW > 13) ? RW : 13;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ADDR, S_WDATA, S_BRESP, S_RDATA, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0]     rem_q;
    logic              dir_q;
    logic [8:0]        blen_q;
    logic [8:0]        cnt_q;
    logic [1:0]        resp_q;
    logic              awvalid_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] axaddr_q;
    logic [7:0]        axlen_q;

    logic [12:0]       beats_4k;
    logic [CW-1:0]     min_w;
    logic [8:0]        blen_n;
    logic [RW-1:0]     rem_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              w_fire;
    logic              w_last;
    logic              r_fire;

    // Burst length: smallest of remaining beats, burst cap and beats to 4 KB page end
    always_comb begin
        beats_4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
        min_w    = CW'(rem_q);
        if (CW'(MAX_BURST_LEN) < min_w) min_w = CW'(MAX_BURST_LEN);
        if (CW'(beats_4k) < min_w)      min_w = CW'(beats_4k);
    end

    assign blen_n  = 9'(min_w);
    assign rem_nx  = rem_q - RW'(blen_q);
    assign addr_nx = addr_q + (ADDR_W'(blen_q) << SZ);
    assign w_last  = (cnt_q + 9'd1) == blen_q;
    assign w_fire  = (state == S_WDATA) && wr_valid && m_axi.m_axi_wready;
    assign r_fire  = (state == S_RDATA) && m_axi.m_axi_rvalid && rd_ready;

    // Transfer sequencer: command latch, burst sizing, channel phases, error merge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            blen_q    <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            axaddr_q  <= '0;
            axlen_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr & ~ADDR_W'(BYTES - 1);
                        rem_q  <= RW'(cmd_len) + RW'(1);
                        dir_q  <= cmd_w_r;
                        resp_q <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    blen_q    <= blen_n;
                    cnt_q     <= '0;
                    axaddr_q  <= addr_q;
                    axlen_q   <= 8'(blen_n - 9'd1);
                    awvalid_q <= !dir_q;
                    arvalid_q <= dir_q;
                    state     <= S_ADDR;
                end
                S_ADDR: begin
                    if (awvalid_q && m_axi.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        state     <= S_WDATA;
                    end else if (arvalid_q && m_axi.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (w_fire) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (w_last) state <= S_BRESP;
                    end
                end
                S_BRESP: begin
                    if (m_axi.m_axi_bvalid) begin
                        if (resp_q == 2'b00) resp_q <= m_axi.m_axi_bresp;
                        rem_q  <= rem_nx;
                        addr_q <= addr_nx;
                        state  <= (rem_nx == '0) ? S_DONE : S_CALC;
                    end
                end
                S_RDATA: begin
                    if (r_fire) begin
                        if (resp_q == 2'b00) resp_q <= m_axi.m_axi_rresp;
                        if (m_axi.m_axi_rlast) begin
                            rem_q  <= rem_nx;
                            addr_q <= addr_nx;
                            state  <= (rem_nx == '0) ? S_DONE : S_CALC;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign resp      = resp_q;

    assign m_axi.m_axi_awaddr  = axaddr_q;
    assign m_axi.m_axi_awlen   = axlen_q;
    assign m_axi.m_axi_awsize  = 3'(SZ);
    assign m_axi.m_axi_awburst = 2'b01;
    assign m_axi.m_axi_awvalid = awvalid_q;

    assign m_axi.m_axi_wdata  = wr_data;
    assign m_axi.m_axi_wstrb  = wr_strb;
    assign m_axi.m_axi_wlast  = (state == S_WDATA) && w_last;
    assign m_axi.m_axi_wvalid = (state == S_WDATA) && wr_valid;
    assign wr_ready           = (state == S_WDATA) && m_axi.m_axi_wready;

    assign m_axi.m_axi_bready = (state == S_BRESP);

    assign m_axi.m_axi_araddr  = axaddr_q;
    assign m_axi.m_axi_arlen   = axlen_q;
    assign m_axi.m_axi_arsize  = 3'(SZ);
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_arvalid = arvalid_q;

    assign m_axi.m_axi_rready = (state == S_RDATA) && rd_ready;
    assign rd_valid           = (state == S_RDATA) && m_axi.m_axi_rvalid;
    assign rd_data            = m_axi.m_axi_rdata;
    assign rd_last            = rd_valid && m_axi.m_axi_rlast &&
                                (rem_q == RW'(blen_q));
endmodule

// File: tb/tb_axi_burst_xfer_master.sv
// Bench for axi_burst_xfer_master: table of transfers against a
// negedge-driven AXI slave and user stream model, plus reset/stall sequences.
module tb_axi_burst_xfer_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_w_r;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        busy, done;
    logic [1:0]  resp;

    always #5 aclk = ~aclk;

    axi_burst_xfer_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_burst_xfer_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST_LEN(16), .XFER_LEN_W(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_ready(rd_ready),
        .busy(busy), .done(done), .resp(resp),
        .m_axi(axi.master)
    );

    typedef struct packed {
        logic            w_r;
        logic [31:0]     addr;
        logic [15:0]     len;
        int              nb;
        logic [3:0][31:0] baddr;
        logic [3:0][7:0] blen;
        logic [3:0][1:0] bresp;
        int              rerr_beat;
        logic [1:0]      rerr;
        logic [1:0]      exp_resp;
        logic            stress;
    } vec_t;

    vec_t v [10];
    vec_t cur;

    int n_cmp = 0;
    int n_bad = 0;
    int nburst, wchk, wb_in, bcnt, b_pend, rbeat, rb_in, rchk;
    int aw_hold, aw_stall, rdlast_cnt;
    int wlen_q[$];
    int rlen_q[$];
    logic        aw_prev;
    logic [31:0] aw_prev_addr;
    logic [7:0]  aw_prev_len;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w_r, input logic [31:0] a,
                                input logic [15:0] l, input int nb,
                                input logic [1:0] er, input logic s);
        vec_t t;
        t = '0;
        t.w_r = w_r; t.addr = a; t.len = l; t.nb = nb;
        t.exp_resp = er; t.stress = s; t.rerr_beat = -1;
        return t;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // AXI slave and user-side stream model: drive on negedge, score handshakes 1 ns later
    always @(negedge aclk) begin
        if (!aresetn) begin
            axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0;
            axi.m_axi_bvalid = 1'b0;  axi.m_axi_bresp = 2'b00;
            axi.m_axi_arready = 1'b0; axi.m_axi_rvalid = 1'b0;
            axi.m_axi_rdata = '0; axi.m_axi_rresp = 2'b00;
            axi.m_axi_rlast = 1'b0;
            wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
            wlen_q.delete(); rlen_q.delete();
            b_pend = 0; wb_in = 0; rb_in = 0; aw_prev = 1'b0;
        end else begin
            axi.m_axi_awready = cur.stress ? rnd() : 1'b1;
            if (aw_hold > 0) axi.m_axi_awready = 1'b0;
            axi.m_axi_arready = cur.stress ? rnd() : 1'b1;
            axi.m_axi_wready  = cur.stress ? rnd() : 1'b1;
            wr_valid = cur.stress ? rnd() : 1'b1;
            wr_data  = {32'hD0D0_0000, 32'(wchk)};
            wr_strb  = 8'(wchk) ^ 8'hA5;
            axi.m_axi_bvalid = (b_pend > 0);
            axi.m_axi_bresp  = (bcnt < 4) ? cur.bresp[bcnt] : 2'b00;
            axi.m_axi_rvalid = (rlen_q.size() > 0) && (cur.stress ? rnd() : 1'b1);
            axi.m_axi_rdata  = {32'hBEEF_0000, 32'(rbeat)};
            axi.m_axi_rlast  = (rlen_q.size() > 0) && (rb_in == rlen_q[0]);
            axi.m_axi_rresp  = (rbeat == cur.rerr_beat) ? cur.rerr : 2'b00;
            rd_ready = cur.stress ? rnd() : 1'b1;
            #1;
            if (axi.m_axi_awvalid) begin
                if (aw_prev) begin
                    chk("aw_stable_addr", axi.m_axi_awaddr, aw_prev_addr);
                    chk("aw_stable_len", axi.m_axi_awlen, aw_prev_len);
                end
                if (axi.m_axi_awready) begin
                    chk("awaddr", axi.m_axi_awaddr, cur.baddr[nburst < 4 ? nburst : 3]);
                    chk("awlen", axi.m_axi_awlen, cur.blen[nburst < 4 ? nburst : 3]);
                    chk("awsize_burst", {axi.m_axi_awsize, axi.m_axi_awburst}, 5'b011_01);
                    wlen_q.push_back(int'(axi.m_axi_awlen));
                    nburst++;
                    aw_prev = 1'b0;
                end else begin
                    aw_prev = 1'b1;
                    aw_prev_addr = axi.m_axi_awaddr;
                    aw_prev_len = axi.m_axi_awlen;
                    aw_stall++;
                    if (aw_hold > 0) aw_hold--;
                end
            end
            if (axi.m_axi_wvalid) chk("w_after_aw", wlen_q.size() > 0, 1);
            if (wr_ready) chk("wr_ready_in_wdata", wlen_q.size() > 0, 1);
            if (axi.m_axi_wvalid && axi.m_axi_wready && wlen_q.size() > 0) begin
                chk("wdata", axi.m_axi_wdata, {32'hD0D0_0000, 32'(wchk)});
                chk("wstrb", axi.m_axi_wstrb, 8'(wchk) ^ 8'hA5);
                chk("wlast", axi.m_axi_wlast, wb_in == wlen_q[0]);
                wchk++;
                if (wb_in == wlen_q[0]) begin
                    void'(wlen_q.pop_front());
                    wb_in = 0;
                    b_pend++;
                end else begin
                    wb_in++;
                end
            end
            if (axi.m_axi_bvalid && axi.m_axi_bready) begin
                b_pend--;
                bcnt++;
            end
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                chk("araddr", axi.m_axi_araddr, cur.baddr[nburst < 4 ? nburst : 3]);
                chk("arlen", axi.m_axi_arlen, cur.blen[nburst < 4 ? nburst : 3]);
                rlen_q.push_back(int'(axi.m_axi_arlen));
                nburst++;
            end
            if (axi.m_axi_rvalid && !rd_ready) chk("rready_bp", axi.m_axi_rready, 0);
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, {32'hBEEF_0000, 32'(rchk)});
                chk("rd_last", rd_last, rchk == int'(cur.len));
                if (rd_last) rdlast_cnt++;
                rchk++;
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) begin
                rbeat++;
                if (axi.m_axi_rlast) begin
                    void'(rlen_q.pop_front());
                    rb_in = 0;
                end else begin
                    rb_in++;
                end
            end
        end
    end

    task automatic start_cmd(input vec_t t, input int hold);
        @(negedge aclk);
        #2;
        cur = t;
        nburst = 0; wchk = 0; bcnt = 0; rbeat = 0; rchk = 0;
        aw_stall = 0; rdlast_cnt = 0; aw_hold = hold;
        cmd_valid = 1'b1; cmd_w_r = t.w_r; cmd_addr = t.addr; cmd_len = t.len;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int hold);
        bit fin;
        start_cmd(t, hold);
        @(negedge aclk);
        chk("busy", busy, 1);
        @(negedge aclk);
        chk("addr_latency", t.w_r ? axi.m_axi_arvalid : axi.m_axi_awvalid, 1);
        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge aclk);
            if (done) begin
                chk("resp_at_done", resp, t.exp_resp);
                fin = 1'b1;
            end
        end
        chk("done_seen", fin, 1);
        @(negedge aclk);
        chk("done_pulse", done, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("resp_held", resp, t.exp_resp);
        chk("bursts", nburst, t.nb);
        chk("beats", t.w_r ? rchk : wchk, int'(t.len) + 1);
        if (t.w_r) chk("rd_last_count", rdlast_cnt, 1);
        else chk("b_count", bcnt, t.nb);
        if (hold > 0) chk("aw_stall_cycles", aw_stall, hold);
    endtask

    task automatic reset_mid();
        bit hit;
        int dones;
        start_cmd(v[1], 0);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge aclk);
            if (wchk >= 5) hit = 1'b1;
        end
        chk("reached_wdata", hit, 1);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        chk("rst_awvalid", axi.m_axi_awvalid, 0);
        chk("rst_wvalid", axi.m_axi_wvalid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_bready", axi.m_axi_bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        nburst = 0;
        dones = 0;
        repeat (10) begin
            @(negedge aclk);
            if (done) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        chk("no_burst_after_reset", nburst, 0);
        chk("cmd_ready_after_reset", cmd_ready, 1);
    endtask

    initial begin
        v[0] = mk(0, 32'h0000_1000, 16'd3, 1, 2'b00, 0);
        v[0].baddr[0] = 32'h1000; v[0].blen[0] = 8'd3;
        v[1] = mk(0, 32'h0000_0000, 16'd39, 3, 2'b00, 0);
        v[1].baddr[0] = 32'h000; v[1].blen[0] = 8'd15;
        v[1].baddr[1] = 32'h080; v[1].blen[1] = 8'd15;
        v[1].baddr[2] = 32'h100; v[1].blen[2] = 8'd7;
        v[2] = mk(1, 32'h0000_0FE0, 16'd7, 2, 2'b00, 0);
        v[2].baddr[0] = 32'h0FE0; v[2].blen[0] = 8'd3;
        v[2].baddr[1] = 32'h1000; v[2].blen[1] = 8'd3;
        v[3] = mk(0, 32'h0000_0FF8, 16'd2, 2, 2'b00, 0);
        v[3].baddr[0] = 32'h0FF8; v[3].blen[0] = 8'd0;
        v[3].baddr[1] = 32'h1000; v[3].blen[1] = 8'd1;
        v[4] = mk(1, 32'h0000_2004, 16'd0, 1, 2'b00, 0);
        v[4].baddr[0] = 32'h2000; v[4].blen[0] = 8'd0;
        v[5] = v[1];
        v[5].bresp[0] = 2'b00; v[5].bresp[1] = 2'b10; v[5].bresp[2] = 2'b11;
        v[5].exp_resp = 2'b10;
        v[6] = mk(1, 32'h0000_3000, 16'd7, 1, 2'b11, 0);
        v[6].baddr[0] = 32'h3000; v[6].blen[0] = 8'd7;
        v[6].rerr_beat = 3; v[6].rerr = 2'b11;
        v[7] = mk(0, 32'hFFFF_FFF0, 16'd3, 2, 2'b00, 0);
        v[7].baddr[0] = 32'hFFFF_FFF0; v[7].blen[0] = 8'd1;
        v[7].baddr[1] = 32'h0000_0000; v[7].blen[1] = 8'd1;
        v[8] = v[1]; v[8].stress = 1'b1;
        v[9] = v[2]; v[9].stress = 1'b1;

        cur = v[0];
        aw_hold = 0;
        cmd_valid = 1'b0; cmd_w_r = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(negedge aclk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_resp", resp, 0);
        chk("reset_awvalid", axi.m_axi_awvalid, 0);
        chk("reset_arvalid", axi.m_axi_arvalid, 0);
        chk("reset_wvalid", axi.m_axi_wvalid, 0);
        chk("reset_bready", axi.m_axi_bready, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_awaddr", axi.m_axi_awaddr, 0);
        chk("reset_awlen", axi.m_axi_awlen, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(v[i], 0);
        run_vec(v[0], 5);
        reset_mid();
        run_vec(v[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
